// File: rtl/morph_frame_ctrl.sv
// Frame-level controller for the binary morphology pipeline.
// Tracks frame/line position from video timing, flags 3x3-window border
// pixels, latches the morphology mode at frame boundaries and checks the
// incoming frame geometry against COL x ROW.
module morph_frame_ctrl #(
  parameter int COL = 1024,
  parameter int ROW = 768
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RGB_de,
  input  logic        RGB_hsync,
  input  logic        RGB_vsync,
  input  logic [1:0]  cfg_mode,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  output logic [1:0]  mode_active,
  output logic        pix_de,
  output logic [10:0] pix_col,
  output logic [9:0]  pix_row,
  output logic        pix_border,
  output logic        frame_start,
  output logic        frame_done,
  output logic        err_line,
  output logic        err_frame,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    WAIT_VS = 2'd0,
    ACTIVE  = 2'd1,
    DONE    = 2'd2
  } state_t;

  localparam logic [10:0] COL_N    = 11'(COL);
  localparam logic [10:0] COL_LAST = 11'(COL - 1);
  localparam logic [9:0]  ROW_N    = 10'(ROW);
  localparam logic [9:0]  ROW_LAST = 10'(ROW - 1);

  // Line sync is carried alongside the pixel stream but not decoded here.
  logic unused_hsync;
  assign unused_hsync = RGB_hsync;

  state_t      state_q, state_d;
  logic        vs_dly_q, vs_dly_d;
  logic        de_dly_q, de_dly_d;
  logic [10:0] x_q, x_d;
  logic [9:0]  y_q, y_d;
  logic [1:0]  pending_q, pending_d;
  logic        pending_full_q, pending_full_d;
  logic [1:0]  mode_active_q, mode_active_d;
  logic        pix_de_q, pix_de_d;
  logic [10:0] pix_col_q, pix_col_d;
  logic [9:0]  pix_row_q, pix_row_d;
  logic        pix_border_q, pix_border_d;
  logic        frame_start_q, frame_start_d;
  logic        frame_done_q, frame_done_d;
  logic        err_line_q, err_line_d;
  logic        err_frame_q, err_frame_d;

  logic        vs_rise;
  logic        de_fall;
  logic        cfg_xfer;
  logic [1:0]  mode_in;
  logic [9:0]  y_inc;
  logic [10:0] x_inc;

  assign vs_rise = RGB_vsync & ~vs_dly_q;
  assign de_fall = ~RGB_de & de_dly_q;

  // Config handshake: a mode transfers on a cycle where cfg_valid and
  // cfg_ready are both high. cfg_ready is high whenever the one-deep pending
  // slot is empty; the slot drains into mode_active only at frame start, so
  // at most one mode change is queued per frame.
  assign cfg_xfer = cfg_valid & ~pending_full_q;
  assign mode_in  = (cfg_mode == 2'd3) ? 2'd0 : cfg_mode;

  // Saturating increments; counters stick at all-ones instead of wrapping.
  assign x_inc = (x_q == 11'h7ff) ? x_q : x_q + 11'd1;
  assign y_inc = (y_q == 10'h3ff) ? y_q : y_q + 10'd1;

  // Next-state, counters, config slot and registered output values.
  always_comb begin
    state_d        = state_q;
    vs_dly_d       = RGB_vsync;
    de_dly_d       = RGB_de;
    x_d            = x_q;
    y_d            = y_q;
    pending_d      = pending_q;
    pending_full_d = pending_full_q;
    mode_active_d  = mode_active_q;
    pix_de_d       = RGB_de;
    pix_col_d      = pix_col_q;
    pix_row_d      = pix_row_q;
    pix_border_d   = 1'b0;
    frame_start_d  = 1'b0;
    frame_done_d   = 1'b0;
    err_line_d     = 1'b0;
    err_frame_d    = 1'b0;

    // A transfer coinciding with frame start goes straight into force.
    if (vs_rise) begin
      if (cfg_xfer) begin
        mode_active_d = mode_in;
      end else if (pending_full_q) begin
        mode_active_d = pending_q;
      end
      pending_full_d = 1'b0;
    end else if (cfg_xfer) begin
      pending_d      = mode_in;
      pending_full_d = 1'b1;
    end

    // Frame start overrides any line end in the same cycle: the partial
    // line is dropped without being counted or length-checked.
    if (vs_rise) begin
      state_d       = ACTIVE;
      frame_start_d = 1'b1;
      err_frame_d   = (state_q == ACTIVE) && (y_q < ROW_N);
      y_d           = 10'd0;
      x_d           = RGB_de ? 11'd1 : 11'd0;
      if (RGB_de) begin
        pix_col_d    = 11'd0;
        pix_row_d    = 10'd0;
        pix_border_d = 1'b1;
      end
    end else begin
      case (state_q)
        ACTIVE: begin
          if (RGB_de) begin
            pix_col_d    = x_q;
            pix_row_d    = y_q;
            pix_border_d = (x_q == 11'd0) || (x_q == COL_LAST) ||
                           (y_q == 10'd0) || (y_q == ROW_LAST);
            x_d          = x_inc;
          end
          if (de_fall) begin
            x_d        = 11'd0;
            y_d        = y_inc;
            err_line_d = (x_q != COL_N);
            if (y_inc == ROW_N) begin
              frame_done_d = 1'b1;
              state_d      = DONE;
            end
          end
        end
        DONE: begin
          if (de_fall) begin
            err_frame_d = 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= WAIT_VS;
      vs_dly_q       <= 1'b0;
      de_dly_q       <= 1'b0;
      x_q            <= 11'd0;
      y_q            <= 10'd0;
      pending_q      <= 2'd0;
      pending_full_q <= 1'b0;
      mode_active_q  <= 2'd0;
      pix_de_q       <= 1'b0;
      pix_col_q      <= 11'd0;
      pix_row_q      <= 10'd0;
      pix_border_q   <= 1'b0;
      frame_start_q  <= 1'b0;
      frame_done_q   <= 1'b0;
      err_line_q     <= 1'b0;
      err_frame_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      vs_dly_q       <= vs_dly_d;
      de_dly_q       <= de_dly_d;
      x_q            <= x_d;
      y_q            <= y_d;
      pending_q      <= pending_d;
      pending_full_q <= pending_full_d;
      mode_active_q  <= mode_active_d;
      pix_de_q       <= pix_de_d;
      pix_col_q      <= pix_col_d;
      pix_row_q      <= pix_row_d;
      pix_border_q   <= pix_border_d;
      frame_start_q  <= frame_start_d;
      frame_done_q   <= frame_done_d;
      err_line_q     <= err_line_d;
      err_frame_q    <= err_frame_d;
    end
  end

  assign cfg_ready   = ~pending_full_q;
  assign mode_active = mode_active_q;
  assign pix_de      = pix_de_q;
  assign pix_col     = pix_col_q;
  assign pix_row     = pix_row_q;
  assign pix_border  = pix_border_q;
  assign frame_start = frame_start_q;
  assign frame_done  = frame_done_q;
  assign err_line    = err_line_q;
  assign err_frame   = err_frame_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_morph_frame_ctrl.sv
// Directed bench for morph_frame_ctrl on a 4x3 frame geometry.
module tb_morph_frame_ctrl;

  localparam int COL = 4;
  localparam int ROW = 3;
  // Scoreboard entry: {check_position, border, col[10:0], row[9:0]}
  localparam int W = 23;

  // ---------------- clock / reset ----------------
  logic        clk;
  logic        rst;
  logic        RGB_de;
  logic        RGB_hsync;
  logic        RGB_vsync;
  logic [1:0]  cfg_mode;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [1:0]  mode_active;
  logic        pix_de;
  logic [10:0] pix_col;
  logic [9:0]  pix_row;
  logic        pix_border;
  logic        frame_start;
  logic        frame_done;
  logic        err_line;
  logic        err_frame;
  logic [1:0]  dbg_state;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  morph_frame_ctrl #(.COL(COL), .ROW(ROW)) dut (
    .clk         (clk),
    .rst         (rst),
    .RGB_de      (RGB_de),
    .RGB_hsync   (RGB_hsync),
    .RGB_vsync   (RGB_vsync),
    .cfg_mode    (cfg_mode),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .mode_active (mode_active),
    .pix_de      (pix_de),
    .pix_col     (pix_col),
    .pix_row     (pix_row),
    .pix_border  (pix_border),
    .frame_start (frame_start),
    .frame_done  (frame_done),
    .err_line    (err_line),
    .err_frame   (err_frame),
    .dbg_state   (dbg_state)
  );

  // ---------------- checking ----------------
  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int cnt_fs = 0;
  int cnt_fd = 0;
  int cnt_el = 0;
  int cnt_ef = 0;

  task automatic push_pix(input bit act, input int c, input int r);
    bit b;
    b = act && (c == 0 || c == COL - 1 || r == 0 || r == ROW - 1);
    exp_q.push_back({act, b, 11'(c), 10'(r)});
  endtask

  // Pops one expectation per output pixel and counts event pulses.
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (frame_start === 1'b1) cnt_fs++;
    if (frame_done  === 1'b1) cnt_fd++;
    if (err_line    === 1'b1) cnt_el++;
    if (err_frame   === 1'b1) cnt_ef++;
    if (pix_de === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("pix_de_unexpected", 32'(pix_de), 32'd0);
      end else begin
        e = exp_q.pop_front();
        if (e[22]) begin
          check("pix_col", 32'(pix_col), 32'(e[20:10]));
          check("pix_row", 32'(pix_row), 32'(e[9:0]));
        end
        check("pix_border", 32'(pix_border), 32'(e[21]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  logic last_fs, last_fd, last_el, last_ef;

  // Apply inputs for one cycle; returns 1 time unit after the sampling edge.
  task automatic step(input logic de, input logic vs);
    RGB_de    = de;
    RGB_vsync = vs;
    RGB_hsync = ~de;
    @(posedge clk);
    #1;
  endtask

  task automatic line(input int n, input int r, input bit act);
    for (int i = 0; i < n; i++) begin
      push_pix(act, i, r);
      step(1'b1, 1'b0);
    end
    step(1'b0, 1'b0);
    last_fd = frame_done;
    last_el = err_line;
    last_ef = err_frame;
    step(1'b0, 1'b0);
  endtask

  task automatic vsync();
    step(1'b0, 1'b1);
    cfg_valid = 1'b0;
    last_fs = frame_start;
    last_ef = err_frame;
    step(1'b0, 1'b0);
  endtask

  task automatic offer(input logic [1:0] m);
    cfg_valid = 1'b1;
    cfg_mode  = m;
    step(1'b0, 1'b0);
    cfg_valid = 1'b0;
    cfg_mode  = 2'd0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; cfg_valid = 1'b0; cfg_mode = 2'd0;
    RGB_de = 1'b0; RGB_vsync = 1'b0; RGB_hsync = 1'b1;
    last_fs = 1'b0; last_fd = 1'b0; last_el = 1'b0; last_ef = 1'b0;
    repeat (3) step(1'b0, 1'b0);
    check("rst_pix_de", 32'(pix_de), 32'd0);
    check("rst_pix_col", 32'(pix_col), 32'd0);
    check("rst_pix_row", 32'(pix_row), 32'd0);
    check("rst_frame_start", 32'(frame_start), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_err_line", 32'(err_line), 32'd0);
    check("rst_err_frame", 32'(err_frame), 32'd0);
    check("rst_mode", 32'(mode_active), 32'd0);
    check("rst_cfg_ready", 32'(cfg_ready), 32'd1);
    rst = 1'b0;
    step(1'b0, 1'b0);

    // Line before any vsync is ignored
    line(4, 0, 1'b0);
    check("wait_err_line", 32'(last_el), 32'd0);
    check("wait_done", 32'(last_fd), 32'd0);
    check("wait_col_hold", 32'(pix_col), 32'd0);

    // Frame 1: clean 4x3, mode 1 offered mid-frame
    vsync();
    check("f1_start", 32'(last_fs), 32'd1);
    check("f1_err_frame", 32'(last_ef), 32'd0);
    line(4, 0, 1'b1);
    check("f1_l0_done", 32'(last_fd), 32'd0);
    offer(2'd1);
    check("f1_cfg_ready_drop", 32'(cfg_ready), 32'd0);
    check("f1_mode_hold", 32'(mode_active), 32'd0);
    line(4, 1, 1'b1);
    check("f1_l1_done", 32'(last_fd), 32'd0);
    check("f1_l1_err_line", 32'(last_el), 32'd0);
    line(4, 2, 1'b1);
    check("f1_l2_done", 32'(last_fd), 32'd1);
    check("f1_mode_still0", 32'(mode_active), 32'd0);

    // Frame 2: mode 1 takes effect; short second line; extra fourth line
    vsync();
    check("f2_start", 32'(last_fs), 32'd1);
    check("f2_err_frame", 32'(last_ef), 32'd0);
    check("f2_mode", 32'(mode_active), 32'd1);
    check("f2_cfg_ready", 32'(cfg_ready), 32'd1);
    line(4, 0, 1'b1);
    line(3, 1, 1'b1);
    check("f2_short_err_line", 32'(last_el), 32'd1);
    check("f2_short_done", 32'(last_fd), 32'd0);
    line(4, 2, 1'b1);
    check("f2_l2_done", 32'(last_fd), 32'd1);
    check("f2_l2_err_line", 32'(last_el), 32'd0);
    line(4, 2, 1'b0);
    check("f2_extra_err_frame", 32'(last_ef), 32'd1);
    check("f2_extra_err_line", 32'(last_el), 32'd0);
    check("f2_extra_done", 32'(last_fd), 32'd0);
    check("f2_col_hold", 32'(pix_col), 32'd3);
    check("f2_row_hold", 32'(pix_row), 32'd2);

    // Frame 3: mode 2 offered together with vsync rise
    cfg_valid = 1'b1;
    cfg_mode  = 2'd2;
    vsync();
    cfg_mode = 2'd0;
    check("f3_start", 32'(last_fs), 32'd1);
    check("f3_err_frame", 32'(last_ef), 32'd0);
    check("f3_mode_direct", 32'(mode_active), 32'd2);
    check("f3_cfg_ready", 32'(cfg_ready), 32'd1);
    line(4, 0, 1'b1);
    offer(2'd3);
    check("f3_cfg_ready_drop", 32'(cfg_ready), 32'd0);
    line(4, 1, 1'b1);

    // Frame 4: vsync after two lines aborts the frame
    vsync();
    check("f4_start", 32'(last_fs), 32'd1);
    check("f4_abort_err_frame", 32'(last_ef), 32'd1);
    check("f4_mode_reserved", 32'(mode_active), 32'd0);
    line(4, 0, 1'b1);
    check("f4_l0_err_line", 32'(last_el), 32'd0);
    offer(2'd1);
    check("f4_cfg_ready_drop", 32'(cfg_ready), 32'd0);
    push_pix(1'b1, 0, 1);
    step(1'b1, 1'b0);
    push_pix(1'b1, 1, 1);
    step(1'b1, 1'b0);
    rst = 1'b1;
    step(1'b1, 1'b0);
    check("mid_rst_pix_de", 32'(pix_de), 32'd0);
    check("mid_rst_pix_col", 32'(pix_col), 32'd0);
    check("mid_rst_pix_row", 32'(pix_row), 32'd0);
    check("mid_rst_cfg_ready", 32'(cfg_ready), 32'd1);
    check("mid_rst_mode", 32'(mode_active), 32'd0);
    step(1'b1, 1'b0);
    rst = 1'b0;
    push_pix(1'b0, 0, 0);
    step(1'b1, 1'b0);
    push_pix(1'b0, 0, 0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    check("post_rst_err_line", 32'(err_line), 32'd0);
    check("post_rst_err_frame", 32'(err_frame), 32'd0);
    step(1'b0, 1'b0);

    // Frame 5: clean frame after reset; the pending mode was discarded
    vsync();
    check("f5_start", 32'(last_fs), 32'd1);
    check("f5_err_frame", 32'(last_ef), 32'd0);
    check("f5_mode", 32'(mode_active), 32'd0);
    line(4, 0, 1'b1);
    line(4, 1, 1'b1);
    check("f5_l1_err_line", 32'(last_el), 32'd0);
    line(4, 2, 1'b1);
    check("f5_done", 32'(last_fd), 32'd1);
    check("f5_err_line", 32'(last_el), 32'd0);

    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    check("sb_drained", 32'(exp_q.size()), 32'd0);
    check("cnt_frame_start", 32'(cnt_fs), 32'd5);
    check("cnt_frame_done", 32'(cnt_fd), 32'd3);
    check("cnt_err_line", 32'(cnt_el), 32'd1);
    check("cnt_err_frame", 32'(cnt_ef), 32'd2);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule

// File: doc/morph_frame_ctrl.md
# morph_frame_ctrl

Frame-level controller for the binary morphology pipeline (3x3 window buffer followed by dilate/erode stage). It tracks frame and line position from the video timing signals and reports window-border flags. It accepts morphology-mode configuration through a valid/ready handshake and applies it only at frame boundaries. It also checks incoming frame geometry against the configured resolution.

## Interface
Parameters:
- COL, 1024, active pixels per line
- ROW, 768, active lines per frame

Ports:
- clk  in  1  pixel clock; the only clock
- rst  in  1  synchronous, active-high reset
- RGB_de  in  1  active-pixel strobe
- RGB_hsync  in  1  line sync (passed through, not decoded)
- RGB_vsync  in  1  frame sync; rising edge = frame start
- cfg_mode  in  2  requested mode: 0 bypass, 1 dilate, 2 erode, 3 reserved (treated as bypass)
- cfg_valid  in  1  cfg_mode offered
- cfg_ready  out  1  pending slot empty; transfer on cfg_valid & cfg_ready
- mode_active  out  2  mode in force for the current frame
- pix_de  out  1  RGB_de delayed 1 clk
- pix_col  out  11  column index of the pix_de pixel
- pix_row  out  10  row index of the pix_de pixel
- pix_border  out  1  pix_de pixel lies on col 0, col COL-1, row 0 or row ROW-1
- frame_start  out  1  one-clk pulse at frame start
- frame_done  out  1  one-clk pulse after ROW lines complete
- err_line  out  1  one-clk pulse: finished line length != COL
- err_frame  out  1  one-clk pulse: frame aborted short or over-long

## Operation
- Edge detect: vs_d, de_d registers. vs_rise = RGB_vsync & ~vs_d. de_fall = ~RGB_de & de_d.
- Counters:
  - x counts RGB_de cycles in the current line. It clears on de_fall.
  - y counts completed lines. It increments on de_fall and clears on vs_rise.
  - x saturates at 2047 and y saturates at 1023. Neither wraps.
- Config:
  - A pending register plus a pending_full flag; cfg_ready = ~pending_full.
  - On vs_rise: mode_active <= the pending value if pending_full, else it is unchanged. pending_full then clears.
  - A transfer in the same cycle as vs_rise bypasses the pending register and loads mode_active directly.
  - mode 3 is stored as 0.
- FSM:
  - WAIT_VS: entered from reset. Lines are ignored. vs_rise -> ACTIVE.
  - ACTIVE: counts lines.
    - When de_fall makes y = ROW: frame_done, then DONE.
    - vs_rise with y < ROW: err_frame, counters restart, and the state stays ACTIVE as a new frame. frame_start fires.
  - DONE: de_fall -> err_frame, state held. vs_rise -> ACTIVE.
- Line check: in ACTIVE, every de_fall with x != COL raises err_line. The line is still counted.
- Border: pix_border = pix_de & (pix_col==0 | pix_col==COL-1 | pix_row==0 | pix_row==ROW-1).
- In WAIT_VS and DONE: pix_de still mirrors RGB_de, pix_border = 0, and pix_col and pix_row hold their last values.

## Timing
- Reset values:
  - All outputs 0, except cfg_ready = 1.
  - mode_active = 0 (bypass).
  - State WAIT_VS.
  - Counters, vs_d, de_d and pending_full are all 0.
- pix_de, pix_col, pix_row and pix_border are registered: 1 clk after the RGB_de cycle they describe.
- frame_start, frame_done, err_line and err_frame are asserted the clk after the triggering edge-detect cycle.
- mode_active updates on the same edge as frame_start. It stays stable for the whole frame.
- Reset mid-frame: everything returns to reset values. The next vs_rise starts a clean frame, and partial lines before it produce no errors.
- Simultaneous de_fall and vs_rise: vs_rise wins. The counters restart, and the line is neither counted nor length-checked.

## Test plan
- Reset, then a 4x3 frame (COL=4, ROW=3) with 2-clk blanking:
  - pix_col runs 0..3 and pix_row runs 0..2.
  - pix_border = 1 except at (1,1) and (2,1).
  - One frame_start, then frame_done 1 clk after the third de_fall.
- Offer cfg_mode=1 mid-frame:
  - cfg_ready drops the next clk.
  - mode_active stays 0 until the next frame_start, then becomes 1.
  - cfg_ready returns to 1 on the same edge.
- Offer cfg_mode=2 with cfg_valid coincident with vs_rise: mode_active = 2 on the frame_start edge, and cfg_ready stays 1.
- Frame of 4 lines where line 2 has 3 pixels:
  - err_line pulses once after line 2.
  - frame_done fires after line 3.
  - The 4th line raises err_frame.
- vs_rise after 2 lines: err_frame and frame_start pulse together, and the counters restart at (0,0).
- Assert rst during line 1 of a frame: outputs return to reset values, and the following full frame completes with no error pulses.
